cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/timeout_ctr.sv | 33 +++
 rtl/cpu_sequencer.sv | 126 ++++++++++++
 tb/tb_cpu_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants plus the sequencer state type.
//   instr_width / op_width : instruction and opcode widths used by the datapath
//   state_t                : sequencer state encoding
//   ctrl_t                 : decoder controls latched in DECODE
package cpu_pkg;

    localparam int instr_width = 32;
    localparam int op_width    = 6;

    typedef enum logic [2:0] {
        ST_START  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic branch;
        logic halt;
    } ctrl_t;

endpackage

// File: rtl/timeout_ctr.sv
// timeout_ctr: counts cycles spent waiting on a memory access.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (held while not waiting)
//   en         : count enable (one per wait cycle)
//   expired    : high during the LIMIT-th wait cycle, i.e. the last one allowed
module timeout_ctr #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    // cnt holds the number of wait cycles already completed, so the
    // LIMIT-th cycle sees cnt == LIMIT-1.
    assign expired = (cnt == W'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !expired)
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle instruction sequencer for a simple CPU.
//   clk, rst_n          : clock, async active-low reset
//   start               : level; high holds the program at START
//   dec_*               : decoder controls, latched in DECODE
//   taken               : ALU branch condition (only comb input->output path)
//   mem_ready           : data RAM acknowledge, looked at only in MEM
//   pc_reset .. mem_wr_en : datapath strobes
//   busy, halt, mem_err : status; mem_err is sticky until START
//   instr_count         : retired instructions, saturating
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dec_mem_read,
    input  logic             dec_mem_write,
    input  logic             dec_reg_write,
    input  logic             dec_branch,
    input  logic             dec_halt,
    input  logic             taken,
    input  logic             mem_ready,
    output logic             pc_reset,
    output logic             ir_load,
    output logic             pc_en,
    output logic             branch_en,
    output logic             reg_write_en,
    output logic             mem_rd_en,
    output logic             mem_wr_en,
    output logic             busy,
    output logic             halt,
    output logic             mem_err,
    output logic [CNT_W-1:0] instr_count
);

    state_t             state;
    ctrl_t              ctrl;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_nxt;
    logic               expired;

    // The wait counter sits at zero outside MEM, so each MEM entry starts fresh.
    timeout_ctr #(.LIMIT(MEM_TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state != ST_MEM),
        .en      (state == ST_MEM),
        .expired (expired)
    );

    // Count retires in WB; going to (or sitting in) START zeroes it so the
    // first START cycle already shows 0.
    always_comb begin
        count_nxt = count_q;
        if (start || state == ST_START)
            count_nxt = '0;
        else if (state == ST_WB && !(&count_q))
            count_nxt = count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_START;
            ctrl    <= '0;
            count_q <= '0;
            mem_err <= 1'b0;
        end else begin
            count_q <= count_nxt;
            if (start || state == ST_START)
                mem_err <= 1'b0;
            if (start) begin
                state <= ST_START;
            end else begin
                case (state)
                    ST_START:  state <= ST_FETCH;
                    ST_FETCH:  state <= ST_DECODE;
                    ST_DECODE: begin
                        ctrl  <= '{mem_read:  dec_mem_read,
                                   mem_write: dec_mem_write,
                                   reg_write: dec_reg_write,
                                   branch:    dec_branch,
                                   halt:      dec_halt};
                        state <= dec_halt ? ST_HALT : ST_EXEC;
                    end
                    ST_EXEC: begin
                        // ctrl.halt is never set here (DECODE already
                        // diverted); kept as a defensive stop.
                        if (ctrl.halt)
                            state <= ST_HALT;
                        else if (ctrl.mem_read || ctrl.mem_write)
                            state <= ST_MEM;
                        else
                            state <= ST_WB;
                    end
                    ST_MEM: begin
                        // A late ack on the final allowed cycle still completes.
                        if (mem_ready)
                            state <= ST_WB;
                        else if (expired) begin
                            mem_err <= 1'b1;
                            state   <= ST_HALT;
                        end
                    end
                    ST_WB:   state <= ST_FETCH;
                    ST_HALT: state <= ST_HALT;
                    default: state <= ST_START;
                endcase
            end
        end
    end

    assign pc_reset     = (state == ST_START);
    assign ir_load      = (state == ST_FETCH);
    assign pc_en        = (state == ST_WB);
    assign branch_en    = (state == ST_WB) && ctrl.branch && taken;
    assign reg_write_en = (state == ST_WB) && ctrl.reg_write && !ctrl.mem_write;
    assign mem_wr_en    = (state == ST_MEM) && ctrl.mem_write;
    assign mem_rd_en    = (state == ST_MEM) && ctrl.mem_read && !ctrl.mem_write;
    assign busy         = (state != ST_START) && (state != ST_HALT);
    assign halt         = (state == ST_HALT);
    assign instr_count  = count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b1;
    logic        dec_mem_read = 1'b0, dec_mem_write = 1'b0, dec_reg_write = 1'b0;
    logic        dec_branch = 1'b0, dec_halt = 1'b0;
    logic        taken = 1'b0, mem_ready = 1'b0;
    logic        pc_reset, ir_load, pc_en, branch_en, reg_write_en;
    logic        mem_rd_en, mem_wr_en, busy, halt, mem_err;
    logic [15:0] instr_count;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(.CNT_W(16), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
        .dec_reg_write(dec_reg_write), .dec_branch(dec_branch), .dec_halt(dec_halt),
        .taken(taken), .mem_ready(mem_ready),
        .pc_reset(pc_reset), .ir_load(ir_load), .pc_en(pc_en), .branch_en(branch_en),
        .reg_write_en(reg_write_en), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .busy(busy), .halt(halt), .mem_err(mem_err), .instr_count(instr_count)
    );

    // {pc_reset, ir_load, pc_en, branch_en, reg_write_en, mem_rd_en, mem_wr_en, busy, halt, mem_err}
    wire [9:0] obs = {pc_reset, ir_load, pc_en, branch_en, reg_write_en,
                      mem_rd_en, mem_wr_en, busy, halt, mem_err};

    localparam logic [9:0] E_START = 10'b1000000000;
    localparam logic [9:0] E_FETCH = 10'b0100000100;
    localparam logic [9:0] E_BUSY  = 10'b0000000100; // DECODE / EXEC
    localparam logic [9:0] E_WB_RW = 10'b0010100100;
    localparam logic [9:0] E_WB    = 10'b0010000100;
    localparam logic [9:0] E_WB_BR = 10'b0011000100;
    localparam logic [9:0] E_MEMRD = 10'b0000010100;
    localparam logic [9:0] E_MEMWR = 10'b0000001100;
    localparam logic [9:0] E_HALT  = 10'b0000000010;
    localparam logic [9:0] E_HERR  = 10'b0000000011;

    // Stimulus only: load decoder inputs, spend one cycle in START, release.
    task automatic restart(input logic rd, input logic wr, input logic rw,
                           input logic br, input logic ht);
        dec_mem_read = rd; dec_mem_write = wr; dec_reg_write = rw;
        dec_branch = br; dec_halt = ht;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (obs !== E_START || instr_count !== 16'd0) begin
            errors++;
            $display("FAIL reset: obs=%b cnt=%0h exp obs=%b cnt=0", obs, instr_count, E_START);
        end
        rst_n = 1'b1;
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== E_START) begin
                errors++;
                $display("FAIL start_hold cyc%0d: obs=%b exp=%b", k, obs, E_START);
            end
        end
    endtask

    task automatic test_alu();
        dec_reg_write = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            logic [9:0] e [4];
            e = '{E_FETCH, E_BUSY, E_BUSY, E_WB_RW};
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                vectors++;
                if (obs !== e[k]) begin
                    errors++;
                    $display("FAIL alu i%0d cyc%0d: obs=%b exp=%b", i, k, obs, e[k]);
                end
            end
            vectors++;
            if (instr_count !== 16'(i)) begin
                errors++;
                $display("FAIL alu_count_wb i%0d: got %0d exp %0d", i, instr_count, i);
            end
        end
        @(negedge clk);
        vectors++;
        if (obs !== E_FETCH || instr_count !== 16'd3) begin
            errors++;
            $display("FAIL alu_count: obs=%b cnt=%0d exp obs=%b cnt=3", obs, instr_count, E_FETCH);
        end
    endtask

    task automatic test_load();
        logic [9:0] e [8];
        e = '{E_FETCH, E_BUSY, E_BUSY, E_MEMRD, E_MEMRD, E_MEMRD, E_WB_RW, E_FETCH};
        mem_ready = 1'b0;
        restart(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== e[k]) begin
                errors++;
                $display("FAIL load cyc%0d: obs=%b exp=%b", k, obs, e[k]);
            end
            if (k == 5) mem_ready = 1'b1;
            if (k == 6) mem_ready = 1'b0;
        end
        vectors++;
        if (instr_count !== 16'd1) begin
            errors++;
            $display("FAIL load_count: got %0d exp 1", instr_count);
        end
    endtask

    // mem_ready held high the whole time: must not short-circuit DECODE/EXEC.
    task automatic test_store();
        logic [9:0] e [6];
        e = '{E_FETCH, E_BUSY, E_BUSY, E_MEMWR, E_WB, E_FETCH};
        mem_ready = 1'b1;
        restart(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== e[k]) begin
                errors++;
                $display("FAIL store cyc%0d: obs=%b exp=%b", k, obs, e[k]);
            end
        end
        mem_ready = 1'b0;
        vectors++;
        if (instr_count !== 16'd1) begin
            errors++;
            $display("FAIL store_count: got %0d exp 1", instr_count);
        end
    endtask

    task automatic test_timeout();
        logic [9:0] e [$];
        e = '{E_FETCH, E_BUSY, E_BUSY, E_WB_RW, E_FETCH, E_BUSY, E_BUSY};
        for (int k = 0; k < 15; k++) e.push_back(E_MEMRD);
        e.push_back(E_HERR);
        e.push_back(E_HERR);
        e.push_back(E_HERR);
        mem_ready = 1'b0;
        restart(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        foreach (e[k]) begin
            @(negedge clk);
            vectors++;
            if (obs !== e[k]) begin
                errors++;
                $display("FAIL timeout cyc%0d: obs=%b exp=%b", k, obs, e[k]);
            end
            if (k == 3) dec_mem_read = 1'b1;
        end
        vectors++;
        if (instr_count !== 16'd1) begin
            errors++;
            $display("FAIL timeout_count: got %0d exp 1", instr_count);
        end
        start = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs !== E_START || instr_count !== 16'd0) begin
            errors++;
            $display("FAIL timeout_clear: obs=%b cnt=%0d exp obs=%b cnt=0", obs, instr_count, E_START);
        end
        start = 1'b0;
        dec_mem_read = 1'b0;
    endtask

    task automatic test_branch_halt();
        logic [9:0] e [11];
        e = '{E_FETCH, E_BUSY, E_BUSY, E_WB_BR,
              E_FETCH, E_BUSY, E_BUSY, E_WB,
              E_FETCH, E_BUSY, E_HALT};
        taken = 1'b1;
        restart(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== e[k]) begin
                errors++;
                $display("FAIL branch cyc%0d: obs=%b exp=%b", k, obs, e[k]);
            end
            if (k == 3) begin
                taken = 1'b0;
                #1;
                vectors++;
                if (branch_en !== 1'b0) begin
                    errors++;
                    $display("FAIL branch_comb: got %b exp 0", branch_en);
                end
            end
            if (k == 7) begin
                dec_branch = 1'b0;
                dec_halt = 1'b1;
            end
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (obs !== E_HALT || instr_count !== 16'd2) begin
            errors++;
            $display("FAIL halt_hold: obs=%b cnt=%0d exp obs=%b cnt=2", obs, instr_count, E_HALT);
        end
        dec_halt = 1'b0;
    endtask

    task automatic test_saturate();
        restart(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);                       // FETCH
        force dut.count_q = 16'hFFFD;
        @(negedge clk);                       // DECODE
        release dut.count_q;
        vectors++;
        if (instr_count !== 16'hFFFD) begin
            errors++;
            $display("FAIL sat_preset: got %0h exp fffd", instr_count);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (obs !== E_FETCH || instr_count !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_fffe: obs=%b cnt=%0h exp obs=%b cnt=fffe", obs, instr_count, E_FETCH);
        end
        for (int i = 0; i < 2; i++) begin
            repeat (4) @(negedge clk);
            vectors++;
            if (obs !== E_FETCH || instr_count !== 16'hFFFF) begin
                errors++;
                $display("FAIL sat_ffff i%0d: obs=%b cnt=%0h exp obs=%b cnt=ffff", i, obs, instr_count, E_FETCH);
            end
        end
    endtask

    task automatic test_reset_in_mem();
        mem_ready = 1'b0;
        restart(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        vectors++;
        if (obs !== E_MEMRD) begin
            errors++;
            $display("FAIL rst_mem_pre: obs=%b exp=%b", obs, E_MEMRD);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== E_START || instr_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_mem_async: obs=%b cnt=%0d exp obs=%b cnt=0", obs, instr_count, E_START);
        end
        @(negedge clk);
        vectors++;
        if (obs !== E_START) begin
            errors++;
            $display("FAIL rst_mem_hold: obs=%b exp=%b", obs, E_START);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs !== E_FETCH || instr_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_mem_resume: obs=%b cnt=%0d exp obs=%b cnt=0", obs, instr_count, E_FETCH);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_timeout();
        test_branch_halt();
        test_saturate();
        test_reset_in_mem();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
